// File: rtl/microseq_next_addr.sv
// ---------------------------------------------------------------------------
// microseq_next_addr
//   Microprogram sequencer for the ARM control unit's 256 x 64 control ROM.
//   Holds the registered microaddress that drives the combinational ROM and,
//   each cycle, picks the next address from the current ROM word's
//   next-address fields, the encoder dispatch address and the condition flags.
//   A small LIFO return stack supports microsubroutine call/return, and an
//   external stall freezes all sequencing state (memory waits).
//
// Ports
//   clk       in   system clock, rising-edge active
//   rst_n     in   asynchronous active-low reset
//   n_sel     in   [2:0] next-address mode (ROM N2-N0)
//   inv       in   invert selected condition (ROM INV)
//   s_sel     in   [2:0] condition select (ROM S2-S0)
//   cr_addr   in   [AW-1:0] jump / call target (ROM CR7-CR0)
//   enc_addr  in   [AW-1:0] dispatch address from the instruction encoder
//   cond_in   in   [7:0] condition vector (bit 7 is constant 1)
//   stall     in   freeze request, highest priority
//   uaddr     out  [AW-1:0] registered current microaddress
//   sp        out  [1:0] return-stack occupancy
//   stk_err   out  one-cycle pulse on stack overflow / underflow
// ---------------------------------------------------------------------------
module microseq_next_addr #(
  parameter int            AW         = 8,
  parameter int            DEPTH      = 2,
  parameter logic [AW-1:0] RESET_ADDR = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [2:0]    n_sel,
  input  logic          inv,
  input  logic [2:0]    s_sel,
  input  logic [AW-1:0] cr_addr,
  input  logic [AW-1:0] enc_addr,
  input  logic [7:0]    cond_in,
  input  logic          stall,
  output logic [AW-1:0] uaddr,
  output logic [1:0]    sp,
  output logic          stk_err
);

  // Internal occupancy is one bit wider than the port so that a full
  // four-entry stack can still be distinguished from an empty one.
  localparam int SPW = 3;

  localparam logic [2:0] N_DISP  = 3'b000;
  localparam logic [2:0] N_JUMP  = 3'b001;
  localparam logic [2:0] N_INCR  = 3'b010;
  localparam logic [2:0] N_CJMP  = 3'b011;
  localparam logic [2:0] N_CDISP = 3'b100;
  localparam logic [2:0] N_CALL  = 3'b101;
  localparam logic [2:0] N_RET   = 3'b110;
  localparam logic [2:0] N_WAIT  = 3'b111;

  logic [AW-1:0]  uaddr_q, uaddr_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           stk_err_q, stk_err_d;
  logic [AW-1:0]  stk_q [DEPTH];
  logic [AW-1:0]  stk_d [DEPTH];

  logic           c;
  logic [AW-1:0]  incr;
  logic [AW-1:0]  top;

  always_comb begin
    c    = cond_in[s_sel] ^ inv;
    incr = uaddr_q + AW'(1);

    // Top-of-stack read: entry[sp-1]; zero when the stack is empty.
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sp_q == SPW'(i + 1)) top = stk_q[i];
    end

    uaddr_d   = uaddr_q;
    sp_d      = sp_q;
    stk_d     = stk_q;
    stk_err_d = 1'b0;

    // Stall freezes everything, including a pending call or return.
    if (!stall) begin
      case (n_sel)
        N_DISP:  uaddr_d = enc_addr;
        N_JUMP:  uaddr_d = cr_addr;
        N_INCR:  uaddr_d = incr;
        N_CJMP:  uaddr_d = c ? cr_addr : incr;
        N_CDISP: uaddr_d = c ? cr_addr : enc_addr;
        N_CALL: begin
          // The jump is taken even on overflow; only the push is dropped.
          uaddr_d = cr_addr;
          if (sp_q == SPW'(DEPTH)) begin
            stk_err_d = 1'b1;
          end else begin
            for (int i = 0; i < DEPTH; i++) begin
              if (sp_q == SPW'(i)) stk_d[i] = incr;
            end
            sp_d = sp_q + SPW'(1);
          end
        end
        N_RET: begin
          // Underflow restarts the fetch microroutine.
          if (sp_q == '0) begin
            uaddr_d   = RESET_ADDR;
            stk_err_d = 1'b1;
          end else begin
            uaddr_d = top;
            sp_d    = sp_q - SPW'(1);
          end
        end
        N_WAIT:  uaddr_d = c ? incr : uaddr_q;
        default: uaddr_d = uaddr_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uaddr_q   <= RESET_ADDR;
      sp_q      <= '0;
      stk_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= '0;
    end else begin
      uaddr_q   <= uaddr_d;
      sp_q      <= sp_d;
      stk_err_q <= stk_err_d;
      for (int i = 0; i < DEPTH; i++) stk_q[i] <= stk_d[i];
    end
  end

  assign uaddr   = uaddr_q;
  assign sp      = (sp_q > SPW'(3)) ? 2'd3 : sp_q[1:0];
  assign stk_err = stk_err_q;

endmodule

// File: tb/tb_microseq_next_addr.sv
module tb_microseq_next_addr;

  logic       clk;
  logic       rst_n;
  logic [2:0] n_sel;
  logic       inv;
  logic [2:0] s_sel;
  logic [7:0] cr_addr;
  logic [7:0] enc_addr;
  logic [7:0] cond_in;
  logic       stall;
  logic [7:0] uaddr;
  logic [1:0] sp;
  logic       stk_err;

  int n_vec;
  int n_bad;

  microseq_next_addr #(.AW(8), .DEPTH(2), .RESET_ADDR(8'd0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .n_sel    (n_sel),
    .inv      (inv),
    .s_sel    (s_sel),
    .cr_addr  (cr_addr),
    .enc_addr (enc_addr),
    .cond_in  (cond_in),
    .stall    (stall),
    .uaddr    (uaddr),
    .sp       (sp),
    .stk_err  (stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] n;
    logic       iv;
    logic [2:0] s;
    logic [7:0] cr;
    logic [7:0] enc;
    logic [7:0] cnd;
    logic       stl;
    logic [7:0] e_ua;
    logic [1:0] e_sp;
    logic       e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic [2:0] n, input logic iv, input logic [2:0] s,
                              input logic [7:0] cr, input logic [7:0] enc, input logic [7:0] cnd,
                              input logic stl, input logic [7:0] e_ua, input logic [1:0] e_sp,
                              input logic e_err);
    vec_t v;
    v.n = n; v.iv = iv; v.s = s; v.cr = cr; v.enc = enc; v.cnd = cnd;
    v.stl = stl; v.e_ua = e_ua; v.e_sp = e_sp; v.e_err = e_err;
    return v;
  endfunction

  task automatic check(input string name, input logic [7:0] e_ua, input logic [1:0] e_sp,
                       input logic e_err);
    n_vec++;
    if (uaddr !== e_ua || sp !== e_sp || stk_err !== e_err) begin
      n_bad++;
      $display("FAIL %s: got uaddr=%0d sp=%0d stk_err=%0b, want uaddr=%0d sp=%0d stk_err=%0b",
               name, uaddr, sp, stk_err, e_ua, e_sp, e_err);
    end
  endtask

  task automatic drive(input vec_t v);
    n_sel = v.n; inv = v.iv; s_sel = v.s; cr_addr = v.cr;
    enc_addr = v.enc; cond_in = v.cnd; stall = v.stl;
  endtask

  task automatic step_chk(input string name, input vec_t v);
    drive(v);
    @(posedge clk);
    #1;
    check(name, v.e_ua, v.e_sp, v.e_err);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b1;
    n_sel = 3'b010; inv = 1'b0; s_sel = 3'd0; cr_addr = 8'd0;
    enc_addr = 8'd0; cond_in = 8'h80; stall = 1'b0;

    // Vectors run back to back from reset; each row is one clock.
    //           n     iv  s  cr   enc  cond  stl  ua   sp err
    tbl.push_back(mk(3'd2, 0, 0, 0,   0,   8'h80, 0, 1,   0, 0)); // 0  incr
    tbl.push_back(mk(3'd2, 0, 0, 0,   0,   8'h80, 0, 2,   0, 0)); // 1
    tbl.push_back(mk(3'd2, 0, 0, 0,   0,   8'h80, 0, 3,   0, 0)); // 2
    tbl.push_back(mk(3'd2, 0, 0, 0,   0,   8'h80, 0, 4,   0, 0)); // 3
    tbl.push_back(mk(3'd7, 0, 0, 99,  0,   8'h80, 0, 4,   0, 0)); // 4  wait MOC=0
    tbl.push_back(mk(3'd7, 0, 0, 99,  0,   8'h80, 0, 4,   0, 0)); // 5
    tbl.push_back(mk(3'd7, 0, 0, 99,  0,   8'h80, 0, 4,   0, 0)); // 6
    tbl.push_back(mk(3'd7, 0, 0, 99,  0,   8'h81, 0, 5,   0, 0)); // 7  MOC=1
    tbl.push_back(mk(3'd1, 0, 0, 4,   0,   8'h80, 0, 4,   0, 0)); // 8  jump
    tbl.push_back(mk(3'd7, 1, 0, 99,  0,   8'h80, 0, 5,   0, 0)); // 9  inv wait
    tbl.push_back(mk(3'd1, 0, 0, 3,   0,   8'h80, 0, 3,   0, 0)); // 10
    tbl.push_back(mk(3'd3, 0, 1, 10,  0,   8'h82, 0, 10,  0, 0)); // 11 cjmp taken
    tbl.push_back(mk(3'd1, 0, 0, 3,   0,   8'h80, 0, 3,   0, 0)); // 12
    tbl.push_back(mk(3'd3, 0, 1, 10,  0,   8'h80, 0, 4,   0, 0)); // 13 cjmp not
    tbl.push_back(mk(3'd0, 0, 0, 0,   25,  8'h80, 0, 25,  0, 0)); // 14 dispatch
    tbl.push_back(mk(3'd4, 1, 7, 40,  33,  8'h80, 0, 33,  0, 0)); // 15 cdisp -> enc
    tbl.push_back(mk(3'd4, 0, 3, 40,  33,  8'h88, 0, 40,  0, 0)); // 16 cdisp Z -> cr
    tbl.push_back(mk(3'd1, 0, 0, 20,  0,   8'h80, 0, 20,  0, 0)); // 17
    tbl.push_back(mk(3'd5, 0, 0, 30,  0,   8'h80, 0, 30,  1, 0)); // 18 call
    tbl.push_back(mk(3'd5, 0, 0, 40,  0,   8'h80, 0, 40,  2, 0)); // 19 call
    tbl.push_back(mk(3'd5, 0, 0, 50,  0,   8'h80, 0, 50,  2, 1)); // 20 overflow
    tbl.push_back(mk(3'd6, 0, 0, 0,   0,   8'h80, 0, 31,  1, 0)); // 21 return
    tbl.push_back(mk(3'd6, 0, 0, 0,   0,   8'h80, 0, 21,  0, 0)); // 22 return
    tbl.push_back(mk(3'd6, 0, 0, 0,   0,   8'h80, 0, 0,   0, 1)); // 23 underflow
    tbl.push_back(mk(3'd2, 0, 0, 0,   0,   8'h80, 0, 1,   0, 0)); // 24
    tbl.push_back(mk(3'd5, 0, 0, 60,  0,   8'h80, 1, 1,   0, 0)); // 25 stalled call
    tbl.push_back(mk(3'd5, 0, 0, 60,  0,   8'h80, 1, 1,   0, 0)); // 26
    tbl.push_back(mk(3'd5, 0, 0, 60,  0,   8'h80, 0, 60,  1, 0)); // 27 call once
    tbl.push_back(mk(3'd6, 0, 0, 0,   0,   8'h80, 1, 60,  1, 0)); // 28 stalled return
    tbl.push_back(mk(3'd6, 0, 0, 0,   0,   8'h80, 0, 2,   0, 0)); // 29 return
    tbl.push_back(mk(3'd6, 0, 0, 0,   0,   8'h80, 1, 2,   0, 0)); // 30 stalled underflow
    tbl.push_back(mk(3'd1, 0, 0, 255, 0,   8'h80, 0, 255, 0, 0)); // 31
    tbl.push_back(mk(3'd2, 0, 0, 0,   0,   8'h80, 0, 0,   0, 0)); // 32 wrap

    // Reset state
    @(negedge clk);
    do_reset();
    check("reset", 8'd0, 2'd0, 1'b0);

    for (int i = 0; i < tbl.size(); i++) begin
      step_chk($sformatf("vec%0d", i), tbl[i]);
    end

    // Asynchronous reset mid-sequence at uaddr=3, seen before the next edge
    do_reset();
    for (int i = 0; i < 3; i++) step_chk("pre_rst", mk(3'd2, 0, 0, 0, 0, 8'h80, 0, 8'(i + 1), 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 8'd0, 2'd0, 1'b0);
    rst_n = 1'b1;
    step_chk("after_rst", mk(3'd2, 0, 0, 0, 0, 8'h80, 0, 1, 0, 0));

    // Reset with a non-empty stack and a pending call in flight
    step_chk("call_a", mk(3'd5, 0, 0, 70, 0, 8'h80, 0, 70, 1, 0));
    drive(mk(3'd5, 0, 0, 80, 0, 8'h80, 0, 0, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_stack", 8'd0, 2'd0, 1'b0);
    @(posedge clk);
    #1;
    check("rst_held", 8'd0, 2'd0, 1'b0);
    rst_n = 1'b1;
    step_chk("ret_empty", mk(3'd6, 0, 0, 0, 0, 8'h80, 0, 0, 0, 1));

    // Reset during a wait that would otherwise hold
    step_chk("jmp9", mk(3'd1, 0, 0, 9, 0, 8'h80, 0, 9, 0, 0));
    step_chk("wait9", mk(3'd7, 0, 0, 0, 0, 8'h80, 0, 9, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_wait", 8'd0, 2'd0, 1'b0);
    rst_n = 1'b1;
    step_chk("wait_from0", mk(3'd7, 0, 0, 0, 0, 8'h81, 0, 1, 0, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
